// File: rtl/bus_sequencer.sv
// Register-transfer sequencer: drives one-hot load/drive enables on a shared bus to perform
// MOVE, SWAP (through an internal temp), LOAD from external data and STORE to external data.
module bus_sequencer #(
    parameter int unsigned NREG = 8,
    parameter int unsigned W    = 32,
    parameter int unsigned IW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [IW-1:0]   req_src,
    input  logic [IW-1:0]   req_dst,
    input  logic [W-1:0]    ext_data_in,
    input  logic [W-1:0]    bus_in,
    output logic [W-1:0]    bus_out,
    output logic            bus_drive,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic [W-1:0]    ext_data_out,
    output logic            ext_valid,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        StIdle, StXfer, StSwap1, StSwap2, StSwap3, StLoad, StStore, StErr
    } state_e;

    localparam logic [1:0] OpMove  = 2'b00;
    localparam logic [1:0] OpSwap  = 2'b01;
    localparam logic [1:0] OpLoad  = 2'b10;
    localparam logic [1:0] OpStore = 2'b11;

    state_e          state_q;
    logic [IW-1:0]   src_q;
    logic [IW-1:0]   dst_q;
    logic [W-1:0]    temp_q;
    logic [W-1:0]    bus_out_q;
    logic            bus_drive_q;
    logic [NREG-1:0] r_in_q;
    logic [NREG-1:0] r_out_q;
    logic [W-1:0]    ext_data_q;
    logic            ext_valid_q;
    logic            done_q;
    logic            err_q;
    logic            req_bad;

    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            v[i] = (idx == IW'(i));
        end
        return v;
    endfunction

    function automatic logic in_range(input logic [IW-1:0] idx);
        return 32'(idx) < NREG;
    endfunction

    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            OpMove, OpSwap: req_bad = (req_src == req_dst) || !in_range(req_src)
                                      || !in_range(req_dst);
            OpLoad:         req_bad = !in_range(req_dst);
            OpStore:        req_bad = !in_range(req_src);
            default:        req_bad = 1'b1;
        endcase
    end

    // Outputs are registered alongside the state, so each is valid for exactly the state's cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            temp_q      <= '0;
            bus_out_q   <= '0;
            bus_drive_q <= 1'b0;
            r_in_q      <= '0;
            r_out_q     <= '0;
            ext_data_q  <= '0;
            ext_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bus_out_q   <= '0;
            bus_drive_q <= 1'b0;
            r_in_q      <= '0;
            r_out_q     <= '0;
            ext_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        src_q <= req_src;
                        dst_q <= req_dst;
                        if (req_bad) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            case (req_op)
                                OpMove: begin
                                    state_q <= StXfer;
                                    r_out_q <= onehot(req_src);
                                    r_in_q  <= onehot(req_dst);
                                    done_q  <= 1'b1;
                                end
                                OpSwap: begin
                                    state_q <= StSwap1;
                                    r_out_q <= onehot(req_src);
                                end
                                OpLoad: begin
                                    state_q     <= StLoad;
                                    bus_drive_q <= 1'b1;
                                    bus_out_q   <= ext_data_in;
                                    r_in_q      <= onehot(req_dst);
                                    done_q      <= 1'b1;
                                end
                                default: begin
                                    state_q <= StStore;
                                    r_out_q <= onehot(req_src);
                                    done_q  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                StSwap1: begin
                    temp_q  <= bus_in;
                    state_q <= StSwap2;
                    r_out_q <= onehot(dst_q);
                    r_in_q  <= onehot(src_q);
                end
                StSwap2: begin
                    state_q     <= StSwap3;
                    bus_drive_q <= 1'b1;
                    bus_out_q   <= temp_q;
                    r_in_q      <= onehot(dst_q);
                    done_q      <= 1'b1;
                end
                StStore: begin
                    ext_data_q  <= bus_in;
                    ext_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                StXfer, StSwap3, StLoad, StErr: state_q <= StIdle;
            endcase
        end
    end

    // Ready is withheld while reset is held so every output reads zero during reset.
    assign req_ready    = (state_q == StIdle) && reset;
    assign bus_out      = bus_out_q;
    assign bus_drive    = bus_drive_q;
    assign r_in         = r_in_q;
    assign r_out        = r_out_q;
    assign ext_data_out = ext_data_q;
    assign ext_valid    = ext_valid_q;
    assign done         = done_q;
    assign err          = err_q;

    a_rout_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_out_q));
    a_no_contend:  assert property (@(posedge clk) disable iff (!reset)
                                    !(bus_drive_q && (|r_out_q)));
    a_bus_quiet:   assert property (@(posedge clk) disable iff (!reset)
                                    bus_drive_q || (bus_out_q == '0));

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer: a per-cycle expectation schedule built from each accepted
// request, compared on every falling edge, plus directed literal checks.
module tb_bus_sequencer;

    localparam int NCYC = 2048;
    localparam logic [1:0] OpMove  = 2'b00;
    localparam logic [1:0] OpSwap  = 2'b01;
    localparam logic [1:0] OpLoad  = 2'b10;
    localparam logic [1:0] OpStore = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_src = 4'd0;
    logic [3:0]  req_dst = 4'd0;
    logic [31:0] ext_data_in = 32'd0;
    logic [31:0] bus_in = 32'd0;
    logic [31:0] bus_out;
    logic        bus_drive;
    logic [7:0]  r_in;
    logic [7:0]  r_out;
    logic [31:0] ext_data_out;
    logic        ext_valid;
    logic        done;
    logic        err;

    bus_sequencer #(.NREG(8), .W(32), .IW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .ext_data_in  (ext_data_in),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_drive    (bus_drive),
        .r_in         (r_in),
        .r_out        (r_out),
        .ext_data_out (ext_data_out),
        .ext_valid    (ext_valid),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic [7:0]  r_in;
        logic [7:0]  r_out;
        logic        drive;
        logic [31:0] bout;
        logic        done;
        logic        err;
        logic        ev;
        logic [31:0] edata;
        logic        rst;
    } exp_t;

    exp_t        exp_tab [NCYC+8];
    logic [31:0] bus_tab [NCYC+8];
    int          cyc = -1;
    int          busy_end = -1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ext_model = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Lay out every output cycle an accepted request produces.
    task automatic accept(input int c, input logic [1:0] op, input logic [3:0] s,
                          input logic [3:0] d, input logic [31:0] x);
        logic [7:0] one;
        logic       bad;
        one = 8'd1;
        bad = ((op != OpLoad) && s >= 4'd8) || ((op != OpStore) && d >= 4'd8)
              || ((op == OpMove || op == OpSwap) && s == d);
        busy_end = c + 1;
        if (bad) begin
            exp_tab[c+1].err = 1'b1;
        end else if (op == OpMove) begin
            exp_tab[c+1].r_out = one << s;
            exp_tab[c+1].r_in  = one << d;
            exp_tab[c+1].done  = 1'b1;
        end else if (op == OpSwap) begin
            exp_tab[c+1].r_out = one << s;
            exp_tab[c+2].r_out = one << d;
            exp_tab[c+2].r_in  = one << s;
            exp_tab[c+3].drive = 1'b1;
            exp_tab[c+3].bout  = bus_tab[c+1];
            exp_tab[c+3].r_in  = one << d;
            exp_tab[c+3].done  = 1'b1;
            busy_end = c + 3;
        end else if (op == OpLoad) begin
            exp_tab[c+1].drive = 1'b1;
            exp_tab[c+1].bout  = x;
            exp_tab[c+1].r_in  = one << d;
            exp_tab[c+1].done  = 1'b1;
        end else begin
            exp_tab[c+1].r_out = one << s;
            exp_tab[c+1].done  = 1'b1;
            exp_tab[c+2].ev    = 1'b1;
            exp_tab[c+2].edata = bus_tab[c+1];
        end
    endtask

    // One clock cycle of stimulus; returns after the falling-edge compare of that cycle.
    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] s,
                        input logic [3:0] d, input logic [31:0] x, input logic rst);
        logic rdy;
        @(posedge clk);
        cyc++;
        #1;
        bus_in = bus_tab[cyc];
        if (rst) begin
            reset = 1'b0;
            req_valid = 1'b0;
            for (int k = 0; k < 5; k++) exp_tab[cyc+k] = '0;
            exp_tab[cyc].rst = 1'b1;
            busy_end = cyc;
            #2;
            check("rst_r_in", 32'(r_in), 32'd0);
            check("rst_r_out", 32'(r_out), 32'd0);
            check("rst_bus", {bus_out[30:0], bus_drive}, 32'd0);
            check("rst_done_err", {30'd0, done, err}, 32'd0);
            #3;
            reset = 1'b1;
        end else begin
            req_valid = v;
            req_op = op;
            req_src = s;
            req_dst = d;
            ext_data_in = x;
            rdy = (cyc > busy_end);
            exp_tab[cyc].ready = rdy;
            if (v && rdy) accept(cyc, op, s, d, x);
            #5;
        end
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 0) begin
            exp_t e;
            e = exp_tab[cyc];
            if (e.rst) ext_model = 32'd0;
            else if (e.ev) ext_model = e.edata;
            check("req_ready", 32'(req_ready), 32'(e.ready));
            check("r_in", 32'(r_in), 32'(e.r_in));
            check("r_out", 32'(r_out), 32'(e.r_out));
            check("bus_drive", 32'(bus_drive), 32'(e.drive));
            check("bus_out", bus_out, e.bout);
            check("done", 32'(done), 32'(e.done));
            check("err", 32'(err), 32'(e.err));
            check("ext_valid", 32'(ext_valid), 32'(e.ev));
            check("ext_data_out", ext_data_out, ext_model);
        end
    end

    initial begin
        int base;
        for (int i = 0; i < NCYC + 8; i++) begin
            exp_tab[i] = '0;
            bus_tab[i] = $urandom;
        end

        step(1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 1'b1);
        idle();
        check("ready_after_reset", 32'(req_ready), 32'd1);

        step(1'b1, OpMove, 4'd2, 4'd5, 32'd0, 1'b0);
        idle();
        check("move_r_out", 32'(r_out), 32'h04);
        check("move_r_in", 32'(r_in), 32'h20);
        check("move_done", 32'(done), 32'd1);
        idle();
        check("move_ready", 32'(req_ready), 32'd1);

        base = cyc + 1;
        bus_tab[base+1] = 32'h0000AAAA;
        bus_tab[base+2] = 32'h00005555;
        step(1'b1, OpSwap, 4'd1, 4'd3, 32'd0, 1'b0);
        idle();
        check("swap1_r_out", 32'(r_out), 32'h02);
        idle();
        check("swap2_r_out", 32'(r_out), 32'h08);
        check("swap2_r_in", 32'(r_in), 32'h02);
        idle();
        check("swap3_drive", 32'(bus_drive), 32'd1);
        check("swap3_bus_out", bus_out, 32'h0000AAAA);
        check("swap3_r_in", 32'(r_in), 32'h08);
        check("swap3_done", 32'(done), 32'd1);
        idle();

        step(1'b1, OpLoad, 4'd0, 4'd7, 32'hDEADBEEF, 1'b0);
        idle();
        check("load_drive", 32'(bus_drive), 32'd1);
        check("load_bus_out", bus_out, 32'hDEADBEEF);
        check("load_r_in", 32'(r_in), 32'h80);
        check("load_done", 32'(done), 32'd1);
        idle();

        base = cyc + 1;
        bus_tab[base+1] = 32'h12345678;
        step(1'b1, OpStore, 4'd0, 4'd0, 32'd0, 1'b0);
        idle();
        check("store_r_out", 32'(r_out), 32'h01);
        check("store_done", 32'(done), 32'd1);
        idle();
        check("store_ext_valid", 32'(ext_valid), 32'd1);
        check("store_ext_data", ext_data_out, 32'h12345678);

        step(1'b1, OpMove, 4'd4, 4'd4, 32'd0, 1'b0);
        idle();
        check("err_same_err", 32'(err), 32'd1);
        check("err_same_quiet", {15'd0, done, r_in, r_out}, 32'd0);
        idle();
        check("err_same_gone", 32'(err), 32'd0);

        step(1'b1, OpSwap, 4'd0, 4'd9, 32'd0, 1'b0);
        idle();
        check("err_range_err", 32'(err), 32'd1);
        check("err_range_quiet", {15'd0, done, r_in, r_out}, 32'd0);
        idle();

        step(1'b1, OpSwap, 4'd2, 4'd6, 32'd0, 1'b0);
        idle();
        step(1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 1'b1);
        idle();
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_no_done", {29'd0, done, |r_in, bus_drive}, 32'd0);
        idle();
        check("abort_no_done2", {29'd0, done, |r_in, bus_drive}, 32'd0);

        while (cyc < NCYC - 16) begin
            step(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), $urandom,
                 ($urandom_range(0, 99) == 0));
        end
        repeat (6) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
